arbitro_rr_param: RTL and testbench
===================================

// Module: arbitro_rr_param
// PURPOSE
//  Parametrised N-port arbiter between the ingress (VC) FIFOs and the egress FIFOs of the transaction layer.
//  Selects one non-empty input FIFO per cycle, pops it and routes the word to the output FIFO named by its
//  destination field (word MSBs), with a registered push one cycle later.
//  Generalises the 4-port fixed-priority arbiter: configurable width/ports, round-robin mode,
//  per-destination backpressure and an explicit IDLE/ACTIVE state.
// PARAMETERS
//  DATA_WIDTH   10  word width; dest = word[DATA_WIDTH-1 -: DEST_W]
//  NUM_PORTS    4   inputs = outputs; power of 2, 2..16
//  DEST_W       2   $clog2(NUM_PORTS); localparam, not overridable
//  RR_MODE      1   0 = fixed priority (port 0 highest), 1 = round-robin
//  BP_MODE      1   0 = global stall if any almostfull; 1 = block only inputs whose head dest is almostfull
// PORTS
//  clk        in   1                      rising-edge clock
//  reset      in   1                      asynchronous, active-high
//  empty      in   NUM_PORTS              input FIFO i empty (bit i)
//  data_in    in   NUM_PORTS*DATA_WIDTH   show-ahead head word of input i, lane [i*DATA_WIDTH +: DATA_WIDTH]
//  almostfull in   NUM_PORTS              output FIFO j almost full (bit j)
//  pop        out  NUM_PORTS              one-hot/zero read enable to input FIFOs, combinational
//  push       out  NUM_PORTS              one-hot/zero write enable to output FIFOs, registered
//  data_out   out  NUM_PORTS*DATA_WIDTH   registered word; only lane of the pushed port non-zero
//  idle       out  1                      registered; 1 when state == IDLE
// BEHAVIOUR
//  - Reset (async, any time): push=0, data_out=0, idle=1, state=IDLE, rr_ptr=0. pop=0 while reset high.
//    An in-flight word at reset is discarded; no partial push after release.
//  - Eligibility of input i: !empty[i] AND
//    BP_MODE=0: ~|almostfull; BP_MODE=1: !almostfull[dest_i], where dest_i = data_in lane i MSBs.
//  - Grant (combinational): RR_MODE=0 -> lowest eligible index. RR_MODE=1 -> first eligible index scanning
//    rr_ptr, rr_ptr+1, ... modulo NUM_PORTS. At most one pop bit per cycle. pop = grant.
//  - On edge after grant g: push[dest_g]<=1, data_out lane dest_g <= data_in lane g; all other lanes/bits 0.
//    If no grant: push<=0, data_out<=0 (no stale data held).
//  - Latency: pop in cycle t -> push/data_out in cycle t+1. Throughput 1 word/cycle, back-to-back allowed.
//  - rr_ptr: after grant g, rr_ptr <= (g+1) mod NUM_PORTS (wraps NUM_PORTS-1 -> 0). Unchanged with no grant.
//    In RR_MODE=0, rr_ptr stays 0.
//  - FSM (2 states, registered):
//    IDLE   -> ACTIVE when a grant occurs.
//    ACTIVE -> IDLE when a cycle has no grant.
//    ACTIVE -> ACTIVE on a further grant.
//    idle output mirrors state.
//  - Almostfull is sampled in the pop cycle. With one word in flight, output FIFOs set their threshold
//    >= 1 below full. Almostfull rising in cycle t+1 does not cancel the push of the word popped in t.
//  - Simultaneous events:
//    * several inputs target the same dest: only the granted one moves.
//    * all inputs empty, or all blocked: pop=0, next push=0.
//  - Only the dest field selects the output; the full word is forwarded unchanged (dest bits included).
//  - Width rule: data_in/data_out lanes are exactly DATA_WIDTH; no truncation or sign extension.
// TESTING
//  1 Reset mid-traffic: reset asserted while push=0100 -> push=0, data_out=0, idle=1 immediately (async).
//    No push in the first cycle after release.
//  2 RR_MODE=1, all 4 non-empty, no almostfull -> pop sequence 0001,0010,0100,1000,0001.
//    Each push one cycle later on the dest of the popped word.
//  3 RR_MODE=0, empty=0000, same stimulus -> pop=0001 every cycle; port 0 starves 1..3.
//  4 BP_MODE=1, inputs 0,1 heads dest=2 and dest=3 (DATA_WIDTH=10: data_in0=10'h2AA, data_in1=10'h3C5),
//    almostfull=0100 -> pop=0010, next cycle push=1000, data_out lane3=10'h3C5.
//  5 BP_MODE=0, same stimulus, almostfull=0100 -> pop=0000, push=0000, idle goes 1 next cycle.
//  6 Single word on input 3 with rr_ptr=3 -> pop=1000. Next cycle rr_ptr=0 (wrap), state ACTIVE,
//    then IDLE one cycle after empty=1111.

Source files
------------

// File: rtl/arbitro_rr_param.sv
// N-port arbiter from ingress FIFOs to egress FIFOs: fixed-priority or round-robin grant,
// destination-aware backpressure, registered push one cycle after the pop.
module arbitro_rr_param #(
  parameter int DATA_WIDTH = 10,
  parameter int NUM_PORTS  = 4,
  parameter int RR_MODE    = 1,
  parameter int BP_MODE    = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            empty,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_PORTS-1:0]            almostfull,
  output logic [NUM_PORTS-1:0]            pop,
  output logic [NUM_PORTS-1:0]            push,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
  output logic                            idle
);

  localparam int DEST_W = $clog2(NUM_PORTS);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  logic                            r_state;
  logic [DEST_W-1:0]               r_rr_ptr;
  logic [NUM_PORTS-1:0]            r_push;
  logic [NUM_PORTS*DATA_WIDTH-1:0] r_data_out;

  logic [DEST_W-1:0]     w_dest [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_elig;
  logic                  w_any_af;
  logic                  w_gnt_vld;
  logic [DEST_W-1:0]     w_gnt_idx;
  logic [DEST_W-1:0]     w_scan;
  logic [DEST_W-1:0]     w_gnt_dest;
  logic [DATA_WIDTH-1:0] w_gnt_word;
  logic [NUM_PORTS-1:0]  w_pop;

  assign w_any_af = |almostfull;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_dest[i] = data_in[i*DATA_WIDTH + DATA_WIDTH - 1 -: DEST_W];
      if (BP_MODE != 0)
        w_elig[i] = !empty[i] && !almostfull[w_dest[i]];
      else
        w_elig[i] = !empty[i] && !w_any_af;
    end
  end

  // Scan starts at rr_ptr in round-robin mode; DEST_W-bit addition wraps modulo NUM_PORTS.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (RR_MODE != 0)
        w_scan = r_rr_ptr + DEST_W'(k);
      else
        w_scan = DEST_W'(k);
      if (!w_gnt_vld && w_elig[w_scan]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
  end

  assign w_gnt_dest = w_dest[w_gnt_idx];
  assign w_gnt_word = data_in[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    w_pop = '0;
    if (w_gnt_vld && !reset)
      w_pop[w_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_push     <= '0;
      r_data_out <= '0;
    end else begin
      r_push     <= '0;
      r_data_out <= '0;
      if (w_gnt_vld) begin
        r_push[w_gnt_dest]                             <= 1'b1;
        r_data_out[w_gnt_dest*DATA_WIDTH +: DATA_WIDTH] <= w_gnt_word;
        r_state                                        <= ST_ACTIVE;
        if (RR_MODE != 0)
          r_rr_ptr <= w_gnt_idx + DEST_W'(1);
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign pop      = w_pop;
  assign push     = r_push;
  assign data_out = r_data_out;
  assign idle     = (r_state == ST_IDLE);

endmodule

// File: tb/tb_arbitro_rr_param.sv
// Directed bench for arbitro_rr_param: three instances (RR+dest BP, fixed priority, RR+global stall)
// share one stimulus bus; each scenario checks the instance whose mode it exercises.
module tb_arbitro_rr_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  empty;
  logic [39:0] data_in;
  logic [3:0]  almostfull;

  logic [3:0]  pop_rr, push_rr, pop_fp, push_fp, pop_gs, push_gs;
  logic [39:0] dout_rr, dout_fp, dout_gs;
  logic        idle_rr, idle_fp, idle_gs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arbitro_rr_param #(.DATA_WIDTH(10), .NUM_PORTS(4), .RR_MODE(1), .BP_MODE(1)) dut_rr (
    .clk(clk), .reset(reset), .empty(empty), .data_in(data_in), .almostfull(almostfull),
    .pop(pop_rr), .push(push_rr), .data_out(dout_rr), .idle(idle_rr));

  arbitro_rr_param #(.DATA_WIDTH(10), .NUM_PORTS(4), .RR_MODE(0), .BP_MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .empty(empty), .data_in(data_in), .almostfull(almostfull),
    .pop(pop_fp), .push(push_fp), .data_out(dout_fp), .idle(idle_fp));

  arbitro_rr_param #(.DATA_WIDTH(10), .NUM_PORTS(4), .RR_MODE(1), .BP_MODE(0)) dut_gs (
    .clk(clk), .reset(reset), .empty(empty), .data_in(data_in), .almostfull(almostfull),
    .pop(pop_gs), .push(push_gs), .data_out(dout_gs), .idle(idle_gs));

  function automatic logic [39:0] lane_vec(input int unsigned l, input logic [9:0] w);
    lane_vec = '0;
    lane_vec[l*10 +: 10] = w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; empty = 4'b1111; almostfull = 4'b0000; data_in = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; empty = 4'b1111; almostfull = 4'b0000; data_in = '0;
    #2;
    total++; if (push_rr !== 4'b0000) begin bad++; $display("FAIL reset_push got=%b exp=0000", push_rr); end
    total++; if (dout_rr !== 40'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0", dout_rr); end
    total++; if (idle_rr !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", idle_rr); end
    total++; if (idle_gs !== 1'b1) begin bad++; $display("FAIL reset_idle_gs got=%b exp=1", idle_gs); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_traffic();
    do_reset();
    empty = 4'b1110; data_in = {30'h0, 10'h2AA};
    #1;
    total++; if (pop_rr !== 4'b0001) begin bad++; $display("FAIL rmid_pop got=%b exp=0001", pop_rr); end
    @(posedge clk); #1;
    total++; if (push_rr !== 4'b0100) begin bad++; $display("FAIL rmid_push got=%b exp=0100", push_rr); end
    #1 reset = 1'b1;
    #1;
    total++; if (push_rr !== 4'b0000) begin bad++; $display("FAIL rmid_async_push got=%b exp=0000", push_rr); end
    total++; if (dout_rr !== 40'h0) begin bad++; $display("FAIL rmid_async_dout got=%h exp=0", dout_rr); end
    total++; if (idle_rr !== 1'b1) begin bad++; $display("FAIL rmid_async_idle got=%b exp=1", idle_rr); end
    total++; if (pop_rr !== 4'b0000) begin bad++; $display("FAIL rmid_async_pop got=%b exp=0000", pop_rr); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (push_rr !== 4'b0000) begin bad++; $display("FAIL rmid_release_push got=%b exp=0000", push_rr); end
    @(posedge clk); #1;
    total++; if (push_rr !== 4'b0100) begin bad++; $display("FAIL rmid_resume_push got=%b exp=0100", push_rr); end
    total++; if (dout_rr !== lane_vec(2, 10'h2AA)) begin bad++; $display("FAIL rmid_resume_dout got=%h exp=%h", dout_rr, lane_vec(2, 10'h2AA)); end
  endtask

  // Lane words: 0->dest1, 1->dest2, 2->dest3, 3->dest0
  task automatic test_round_robin();
    logic [3:0] exp_pop  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_push [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    int unsigned exp_dest [5] = '{1, 2, 3, 0, 1};
    logic [9:0] exp_word [5] = '{10'h155, 10'h2A3, 10'h30F, 10'h0C7, 10'h155};
    do_reset();
    empty = 4'b0000; data_in = {10'h0C7, 10'h30F, 10'h2A3, 10'h155};
    for (int s = 0; s < 5; s++) begin
      #1;
      total++; if (pop_rr !== exp_pop[s]) begin bad++; $display("FAIL rr_pop[%0d] got=%b exp=%b", s, pop_rr, exp_pop[s]); end
      @(posedge clk); #1;
      total++; if (push_rr !== exp_push[s]) begin bad++; $display("FAIL rr_push[%0d] got=%b exp=%b", s, push_rr, exp_push[s]); end
      total++; if (dout_rr !== lane_vec(exp_dest[s], exp_word[s])) begin bad++; $display("FAIL rr_dout[%0d] got=%h exp=%h", s, dout_rr, lane_vec(exp_dest[s], exp_word[s])); end
      total++; if (idle_rr !== 1'b0) begin bad++; $display("FAIL rr_idle[%0d] got=%b exp=0", s, idle_rr); end
      @(negedge clk);
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    empty = 4'b0000; data_in = {10'h0C7, 10'h30F, 10'h2A3, 10'h155};
    for (int s = 0; s < 5; s++) begin
      #1;
      total++; if (pop_fp !== 4'b0001) begin bad++; $display("FAIL fp_pop[%0d] got=%b exp=0001", s, pop_fp); end
      @(posedge clk); #1;
      total++; if (push_fp !== 4'b0010) begin bad++; $display("FAIL fp_push[%0d] got=%b exp=0010", s, push_fp); end
      total++; if (dout_fp !== lane_vec(1, 10'h155)) begin bad++; $display("FAIL fp_dout[%0d] got=%h exp=%h", s, dout_fp, lane_vec(1, 10'h155)); end
      @(negedge clk);
    end
  endtask

  task automatic test_dest_backpressure();
    do_reset();
    empty = 4'b1100; data_in = {20'h0, 10'h3C5, 10'h2AA}; almostfull = 4'b0100;
    #1;
    total++; if (pop_rr !== 4'b0010) begin bad++; $display("FAIL bp1_pop got=%b exp=0010", pop_rr); end
    @(posedge clk); #1;
    total++; if (push_rr !== 4'b1000) begin bad++; $display("FAIL bp1_push got=%b exp=1000", push_rr); end
    total++; if (dout_rr !== lane_vec(3, 10'h3C5)) begin bad++; $display("FAIL bp1_dout got=%h exp=%h", dout_rr, lane_vec(3, 10'h3C5)); end
  endtask

  task automatic test_global_stall();
    do_reset();
    empty = 4'b1100; data_in = {20'h0, 10'h3C5, 10'h2AA}; almostfull = 4'b0000;
    #1;
    total++; if (pop_gs !== 4'b0001) begin bad++; $display("FAIL gs_pre_pop got=%b exp=0001", pop_gs); end
    @(posedge clk); #1;
    total++; if (push_gs !== 4'b0100) begin bad++; $display("FAIL gs_pre_push got=%b exp=0100", push_gs); end
    total++; if (idle_gs !== 1'b0) begin bad++; $display("FAIL gs_pre_idle got=%b exp=0", idle_gs); end
    @(negedge clk);
    almostfull = 4'b0100;
    #1;
    total++; if (pop_gs !== 4'b0000) begin bad++; $display("FAIL gs_pop got=%b exp=0000", pop_gs); end
    @(posedge clk); #1;
    total++; if (push_gs !== 4'b0000) begin bad++; $display("FAIL gs_push got=%b exp=0000", push_gs); end
    total++; if (dout_gs !== 40'h0) begin bad++; $display("FAIL gs_dout got=%h exp=0", dout_gs); end
    total++; if (idle_gs !== 1'b1) begin bad++; $display("FAIL gs_idle got=%b exp=1", idle_gs); end
  endtask

  task automatic test_wrap_and_idle();
    do_reset();
    empty = 4'b1011; data_in = {10'h0, 10'h1AB, 20'h0};
    #1;
    total++; if (pop_rr !== 4'b0100) begin bad++; $display("FAIL wr_pop2 got=%b exp=0100", pop_rr); end
    @(negedge clk);
    empty = 4'b0111; data_in = {10'h3E1, 30'h0};
    #1;
    total++; if (pop_rr !== 4'b1000) begin bad++; $display("FAIL wr_pop3 got=%b exp=1000", pop_rr); end
    @(posedge clk); #1;
    total++; if (push_rr !== 4'b1000) begin bad++; $display("FAIL wr_push3 got=%b exp=1000", push_rr); end
    total++; if (dout_rr !== lane_vec(3, 10'h3E1)) begin bad++; $display("FAIL wr_dout3 got=%h exp=%h", dout_rr, lane_vec(3, 10'h3E1)); end
    total++; if (idle_rr !== 1'b0) begin bad++; $display("FAIL wr_active got=%b exp=0", idle_rr); end
    @(negedge clk);
    empty = 4'b1111;
    #1;
    total++; if (pop_rr !== 4'b0000) begin bad++; $display("FAIL wr_empty_pop got=%b exp=0000", pop_rr); end
    @(posedge clk); #1;
    total++; if (idle_rr !== 1'b1) begin bad++; $display("FAIL wr_idle got=%b exp=1", idle_rr); end
    total++; if (push_rr !== 4'b0000) begin bad++; $display("FAIL wr_idle_push got=%b exp=0000", push_rr); end
    @(negedge clk);
    // Inputs 0 and 2 both ready: a wrapped pointer (0) picks input 0.
    empty = 4'b1010; data_in = {10'h0, 10'h1AB, 10'h0, 10'h2AA};
    #1;
    total++; if (pop_rr !== 4'b0001) begin bad++; $display("FAIL wr_ptr_pop got=%b exp=0001", pop_rr); end
    @(posedge clk); #1;
    total++; if (push_rr !== 4'b0100) begin bad++; $display("FAIL wr_ptr_push got=%b exp=0100", push_rr); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_traffic();
    test_round_robin();
    test_fixed_priority();
    test_dest_backpressure();
    test_global_stall();
    test_wrap_and_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
